// File: rtl/array_port_pkg.sv
// Shared types and constants for the array port master: FSM encoding,
// read latency, parameter defaults and the in-flight read tag.
package array_port_pkg;

  localparam int ADDRBIT_DEF = 6;
  localparam int DEPTH_DEF   = 48;
  localparam int WIDTH_DEF   = 80;
  localparam int RD_LAT      = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RMW_RD = 3'd1,
    RMW_W1 = 3'd2,
    RMW_W2 = 3'd3,
    RMW_WR = 3'd4
  } state_t;

  typedef struct packed {
    logic vld;
    logic err;
    logic rmw;
  } rd_tag_t;

endpackage

// File: rtl/array_port_rdpipe.sv
// In-flight read tag pipeline; a tag pops out RD_LAT cycles after push,
// lined up with the RAM's registered output.
module array_port_rdpipe
  import array_port_pkg::*;
(
  input  logic    clk0,
  input  logic    p0rst_,
  input  rd_tag_t push,
  output rd_tag_t pop,
  output logic    pend
);

  rd_tag_t tag_pipe [RD_LAT:1];

  always_ff @(posedge clk0 or negedge p0rst_) begin
    if (!p0rst_) begin
      for (int i = 1; i <= RD_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[1] <= push;
      for (int i = 2; i <= RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign pop = tag_pipe[RD_LAT];

  always_comb begin
    pend = 1'b0;
    for (int i = 1; i <= RD_LAT; i++) pend = pend | tag_pipe[i].vld;
  end

endmodule

// File: rtl/array_port_master.sv
// Host request port onto a sync RAM with 2-cycle registered read data.
// Define ARRAY_PORT_MASTER_RMW_EN to do partial-mask writes as read-modify-write.
module array_port_master
  import array_port_pkg::*;
#(
  parameter int ADDRBIT = ADDRBIT_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int WIDTH   = WIDTH_DEF
)(
  input  logic               clk0,
  input  logic               p0rst_,
  input  logic               req_vld,
  output logic               req_rdy,
  input  logic               req_wr,
  input  logic [ADDRBIT-1:0] req_addr,
  input  logic [WIDTH-1:0]   req_data,
  input  logic [WIDTH-1:0]   req_mask,
  output logic               rsp_vld,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_err,
  output logic [ADDRBIT-1:0] ram_a,
  output logic               ram_we,
  output logic               ram_re,
  output logic [WIDTH-1:0]   ram_di,
  input  logic [WIDTH-1:0]   ram_do,
  output logic               busy
);

  state_t             state;
  logic               acc, in_rng, host_rd, host_wr, full_wr, rmw_rd, rmw_wr, rd_pend;
  logic [ADDRBIT-1:0] rmw_addr, a_q;
  logic [WIDTH-1:0]   rmw_di, di_q;
  rd_tag_t            push, pop;

  assign req_rdy = p0rst_ & (state == IDLE);
  assign acc     = req_vld & req_rdy;
  assign in_rng  = 32'(req_addr) < 32'(DEPTH);
  assign host_rd = acc & ~req_wr;
  assign host_wr = acc & req_wr & in_rng;

`ifdef ARRAY_PORT_MASTER_RMW_EN
  logic [WIDTH-1:0] rmw_data, rmw_mask, rmw_old;
  logic             rmw_go;

  assign full_wr = host_wr & (&req_mask);
  assign rmw_go  = host_wr & ~(&req_mask);
  assign rmw_rd  = (state == RMW_RD);
  assign rmw_wr  = (state == RMW_WR);
  assign rmw_di  = (rmw_old & ~rmw_mask) | (rmw_data & rmw_mask);

  // Old word is captured in RMW_W2, the cycle its read tag pops out.
  always_ff @(posedge clk0 or negedge p0rst_) begin
    if (!p0rst_) begin
      state    <= IDLE;
      rmw_addr <= '0;
      rmw_data <= '0;
      rmw_mask <= '0;
      rmw_old  <= '0;
    end else begin
      case (state)
        IDLE: if (rmw_go) begin
          state    <= RMW_RD;
          rmw_addr <= req_addr;
          rmw_data <= req_data;
          rmw_mask <= req_mask;
        end
        RMW_RD:  state <= RMW_W1;
        RMW_W1:  state <= RMW_W2;
        RMW_W2: begin
          state   <= RMW_WR;
          rmw_old <= ram_do;
        end
        RMW_WR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic mask_unused;

  assign mask_unused = ^req_mask;
  assign state       = IDLE;
  assign full_wr     = host_wr;
  assign rmw_rd      = 1'b0;
  assign rmw_wr      = 1'b0;
  assign rmw_addr    = '0;
  assign rmw_di      = '0;
`endif

  assign ram_re = (host_rd & in_rng) | rmw_rd;
  assign ram_we = full_wr | rmw_wr;

  // Address/data hold their last driven value between accesses.
  always_comb begin
    ram_a  = a_q;
    ram_di = di_q;
    if ((host_rd & in_rng) | full_wr) ram_a = req_addr;
    else if (rmw_rd | rmw_wr)         ram_a = rmw_addr;
    if (full_wr)     ram_di = req_data;
    else if (rmw_wr) ram_di = rmw_di;
  end

  always_ff @(posedge clk0 or negedge p0rst_) begin
    if (!p0rst_) begin
      a_q  <= '0;
      di_q <= '0;
    end else begin
      a_q  <= ram_a;
      di_q <= ram_di;
    end
  end

  always_comb begin
    push     = '0;
    push.vld = host_rd | rmw_rd;
    push.err = host_rd & ~in_rng;
    push.rmw = rmw_rd;
  end

  array_port_rdpipe u_rdpipe (
    .clk0   (clk0),
    .p0rst_ (p0rst_),
    .push   (push),
    .pop    (pop),
    .pend   (rd_pend)
  );

  // RMW reads retire silently; out-of-range reads return zero with err.
  assign rsp_vld  = pop.vld & ~pop.rmw;
  assign rsp_err  = rsp_vld & pop.err;
  assign rsp_data = (rsp_vld & ~pop.err) ? ram_do : '0;
  assign busy     = rd_pend | (state != IDLE);

endmodule
